uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the receive FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, meaning the byte width taken from the receiver.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port rx_valid, input, 1, the receiver byte-available level (held until acknowledged).
REQ-006 SHALL have port rx_data, input, PAYLOAD_BITS, the receiver byte, stable while rx_valid=1.
REQ-007 SHALL have port rx_read, output, 1, a one-cycle acknowledge to the receiver that clears its held byte.
REQ-008 SHALL have port rd_pop, input, 1, a consumer pop of the FIFO head.
REQ-009 SHALL have port rd_data, output, PAYLOAD_BITS, the FIFO head byte, meaningful only when rd_valid=1.
REQ-010 SHALL have port rd_valid, output, 1, FIFO not empty.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1, the current FIFO occupancy.
REQ-012 SHALL have port flush, input, 1, a synchronous FIFO clear.

Function
REQ-013 SHALL implement FSM states IDLE, ACK and WAIT.
REQ-014 IDLE: when rx_valid=1 and the FIFO has space (level<DEPTH, or level==DEPTH with rd_pop=1 the same cycle), SHALL write rx_data at the edge and go to ACK; otherwise SHALL stay in IDLE.
REQ-015 ACK: SHALL drive rx_read=1 for exactly this one cycle, then go to WAIT.
REQ-016 WAIT: SHALL drive rx_read=0; when rx_valid=0, SHALL go to IDLE; otherwise SHALL stay in WAIT (guards against double-capture of the same byte).
REQ-017 rx_read SHALL be a registered output, high only in ACK.
REQ-018 With the FIFO full and no pop, SHALL leave the receiver byte unacknowledged (backpressure); the receiver holds the byte and deasserts flow control.
REQ-019 A written byte SHALL appear at rd_data with rd_valid=1 in the cycle after the write edge (1-cycle latency).
REQ-020 rd_pop with rd_valid=1 SHALL advance the head at the edge; rd_pop with rd_valid=0 SHALL be ignored, with no pointer or level change.
REQ-021 Simultaneous write and pop SHALL leave level unchanged, including at level==DEPTH and level==1.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL saturate at neither end beyond 0..DEPTH.
REQ-023 FIFO order SHALL be strictly first-in first-out across pointer wrap.
REQ-024 flush=1 SHALL set level=0, rd_valid=0 and equal pointers at the edge.
REQ-025 flush SHALL take priority over a same-cycle write and pop.
REQ-026 flush SHALL not alter the FSM state, so an in-progress ACK/WAIT handshake completes normally.
REQ-027 rd_data SHALL read directly from the FIFO head entry, with no extra register stage.

Reset
REQ-028 Reset assertion SHALL immediately force FSM=IDLE, rx_read=0, pointers=0, level=0 and rd_valid=0.
REQ-029 FIFO storage contents SHALL not need reset.
REQ-030 A reset asserted mid-handshake SHALL abandon it; after release, a byte still held by the receiver SHALL be captured again from IDLE.

Structure
REQ-031 The FSM state encoding (IDLE=0, ACK=1, WAIT=2, 2 bits) SHALL live in a shared package uart_pkg, alongside the default PAYLOAD_BITS.
REQ-032 Storage and pointers SHALL be one sub-module, sync_byte_fifo (DEPTH, PAYLOAD_BITS; push, pop, flush, head, level); the FSM and handshake SHALL live in uart_rx_ctrl.

Verification
REQ-033 Single byte: rx_valid=1, rx_data=0x5A in IDLE -> write edge; next cycle rx_read=1 for 1 cycle; following cycle rd_valid=1, rd_data=0x5A, level=1.
REQ-034 Fill and backpressure (DEPTH=4): send 0x01..0x05 -> four acks, level=4; byte 0x05 stays unacked with rx_read=0 until one pop; then 0x05 is captured and pops yield 0x01..0x05 in order.
REQ-035 Simultaneous push/pop at full: level=4, rx_valid=1 with rd_pop=1 same cycle -> level stays 4, head advances, new byte becomes the tail.
REQ-036 Wrap: 10 bytes 0x10..0x19, each popped after capture -> output sequence exact, pointers wrap twice, level never >1.
REQ-037 Flush: level=3, flush=1 with rd_pop=1 and a write the same cycle -> level=0, rd_valid=0; a pending ACK still gives one rx_read pulse.
REQ-038 Reset mid-ACK: assert reset while in ACK -> rx_read=0 immediately, level=0; after release, the held byte 0xA5 is captured once, level=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: handshake FSM encoding and
// the default byte width delivered by the receiver.
package uart_pkg;

    localparam int UART_PAYLOAD_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with occupancy count, synchronous flush and a
// combinational head read so a written byte is visible one cycle after push.
module sync_byte_fifo #(
    parameter int DEPTH        = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] din,
    output logic [PAYLOAD_BITS-1:0] head,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W:0]          level_q;
    logic                    pop_ok;
    logic                    push_ok;

    // Pops on empty are dropped; a push at full is only legal alongside a pop.
    assign pop_ok  = pop && (level_q != '0);
    assign push_ok = push && ((level_q != FULL_LVL) || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Moves bytes from a level-valid UART receiver into a small FIFO, returning a
// one-cycle acknowledge per byte and holding off while the FIFO is full.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_read,
    input  logic                    rd_pop,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    input  logic                    flush
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic             rx_read_q;
    logic             push;
    logic             has_space;
    logic [LVL_W-1:0] level_w;

    // A pop at full frees the slot at the same edge the new byte lands.
    assign has_space = (level_w != FULL_LVL) || rd_pop;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && has_space) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:  state_d = WAIT;
            WAIT: begin
                if (!rx_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush deliberately leaves the handshake alone so an owed ack still goes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_read_q <= (state_d == ACK);
        end
    end

    sync_byte_fifo #(
        .DEPTH        (DEPTH),
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_pop),
        .flush (flush),
        .din   (rx_data),
        .head  (rd_data),
        .level (level_w)
    );

    assign rx_read  = rx_read_q;
    assign rd_valid = (level_w != '0);
    assign level    = level_w;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO and receiver handshake.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int PB    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [PB-1:0] rx_data = '0;
    logic          rx_read;
    logic          rd_pop = 1'b0;
    logic [PB-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    level;
    logic          flush = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_read  (rx_read),
        .rd_pop   (rd_pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .flush    (flush)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  mq[$];       // expected FIFO contents, head first
    int          m_phase = 0; // 0 free, 1 acknowledging, 2 waiting for receiver to drop valid
    bit          hold_off = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("level", 32'(level), 32'(mq.size()));
        check_eq("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        check_eq("rx_read", 32'(rx_read), 32'(m_phase == 1));
        if (mq.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    // One clock: predict from the inputs now applied, pass the edge, update the
    // model, then let the receiver drop its byte if it was just acknowledged.
    task automatic tick();
        bit cap, pop_ok, clr;
        cap = (m_phase == 0) && rx_valid &&
              ((mq.size() < DEPTH) || ((mq.size() == DEPTH) && rd_pop));
        pop_ok = rd_pop && (mq.size() > 0);
        clr = (m_phase == 1);
        @(posedge clk);
        if (pop_ok && !flush) $display("pop     0x%02h level %0d", mq[0], mq.size());
        if (cap) $display("capture 0x%02h%s", rx_data, flush ? " (flushed)" : "");
        if (flush) mq.delete();
        else begin
            if (pop_ok) void'(mq.pop_front());
            if (cap) mq.push_back(rx_data);
        end
        case (m_phase)
            0: if (cap) m_phase = 1;
            1: m_phase = 2;
            default: if (!rx_valid) m_phase = 0;
        endcase
        hold_off = clr;
        @(negedge clk);
        if (clr) rx_valid = 1'b0;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && rx_valid; i++) tick();
        check_eq("send_acked", 32'(rx_valid), 32'd0);
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] b);
        check_eq(tag, 32'(rd_data), 32'(b));
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    task automatic finish_handshake();
        for (int i = 0; i < 10 && rx_valid; i++) tick();
        check_eq("hs_done", 32'(rx_valid), 32'd0);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rx_read", 32'(rx_read), 32'd0);
        reset = 1'b0;
        check_all();

        // single byte
        rx_data = 8'h5A; rx_valid = 1'b1;
        tick();
        check_eq("single_rx_read", 32'(rx_read), 32'd1);
        tick();
        check_eq("single_rx_read_1cyc", 32'(rx_read), 32'd0);
        check_eq("single_rd_data", 32'(rd_data), 32'h5A);
        check_eq("single_level", 32'(level), 32'd1);
        tick();
        pop_expect("single_pop", 8'h5A);

        // fill and backpressure
        for (int b = 1; b <= 4; b++) send_byte(8'(b));
        check_eq("fill_level", 32'(level), 32'd4);
        rx_data = 8'h05; rx_valid = 1'b1;
        repeat (4) tick();
        check_eq("bp_rx_read", 32'(rx_read), 32'd0);
        check_eq("bp_level", 32'(level), 32'd4);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check_eq("bp_capture_level", 32'(level), 32'd4);
        check_eq("bp_capture_ack", 32'(rx_read), 32'd1);
        finish_handshake();
        for (int b = 2; b <= 5; b++) pop_expect("fill_order", 8'(b));
        check_eq("fill_empty", 32'(level), 32'd0);

        // simultaneous push and pop at full
        for (int b = 0; b < 4; b++) send_byte(8'(8'h21 + b));
        rx_data = 8'h25; rx_valid = 1'b1; rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check_eq("full_pp_level", 32'(level), 32'd4);
        check_eq("full_pp_head", 32'(rd_data), 32'h22);
        finish_handshake();
        for (int b = 0; b < 4; b++) pop_expect("full_pp_order", 8'(8'h22 + b));

        // pointer wrap
        for (int k = 0; k < 10; k++) begin
            send_byte(8'(8'h10 + k));
            check_eq("wrap_level", 32'(level), 32'd1);
            pop_expect("wrap_data", 8'(8'h10 + k));
        end
        check_eq("wrap_empty", 32'(level), 32'd0);

        // flush beats same-cycle write and pop, ack still delivered
        for (int b = 0; b < 3; b++) send_byte(8'(8'h31 + b));
        rx_data = 8'h34; rx_valid = 1'b1; rd_pop = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; rd_pop = 1'b0;
        check_eq("flush_level", 32'(level), 32'd0);
        check_eq("flush_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("flush_ack", 32'(rx_read), 32'd1);
        finish_handshake();

        // reset in the middle of an acknowledge
        rx_data = 8'hA5; rx_valid = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_ack_rx_read", 32'(rx_read), 32'd0);
        check_eq("rst_ack_level", 32'(level), 32'd0);
        check_eq("rst_ack_rd_valid", 32'(rd_valid), 32'd0);
        mq.delete(); m_phase = 0; hold_off = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
        tick();
        check_eq("rst_recapture_ack", 32'(rx_read), 32'd1);
        finish_handshake();
        repeat (3) tick();
        check_eq("rst_recapture_level", 32'(level), 32'd1);
        pop_expect("rst_recapture_data", 8'hA5);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!rx_valid && !hold_off && $urandom_range(0, 2) == 0) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
            end
            rd_pop = ($urandom_range(0, 99) < ((i < 750) ? 35 : 15));
            flush  = ($urandom_range(0, 59) == 0);
            tick();
        end
        rd_pop = 1'b0;
        flush  = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
